// File: rtl/serial_stim_feeder_pkg.sv
// Shared types and constants for the serial stimulus feeder.
// Frame length depends on SER_PARITY_EN (adds one even-parity bit per word).
package project2_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    localparam logic IDLE_X = 1'b1;

    function automatic int unsigned frame_len(input int unsigned data_w);
`ifdef SER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/serial_stim_feeder_if.sv
// Valid/ready word stream into the serial stimulus feeder.
interface serial_stim_feeder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_stim_feeder_fifo.sv
// Synchronous word FIFO with occupancy count; push when full and pop when empty are ignored.
module ser_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/serial_stim_feeder.sv
// Serialises FIFO words LSB first onto x, one bit per tick; x parks at 1 when idle.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module serial_stim_feeder
    import project2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       tick,
    serial_stim_feeder_if.slave        in_if,
    output logic                       x,
    output logic                       x_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int unsigned FRAME = frame_len(DATA_W);
    localparam int          CW    = $clog2(FRAME + 1);

    ser_state_t        state_q, state_d;
    logic [FRAME-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] head;
    logic [FRAME-1:0]  head_frame;
    logic              full, empty, last_bit, pop;

    ser_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .r       (r),
        .push_i  (in_if.in_valid & in_if.in_ready),
        .wdata_i (in_if.in_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

`ifdef SER_PARITY_EN
    assign head_frame = {^head, head};
`else
    assign head_frame = head;
`endif

    assign last_bit = (bitcnt_q == CW'(FRAME - 1));
    // A pop either starts a frame from idle or chains onto the last bit with no gap.
    assign pop = tick & ~empty & ((state_q == SER_IDLE) | ((state_q == SER_SHIFT) & last_bit));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (tick) begin
            case (state_q)
                SER_IDLE: begin
                    if (pop) begin
                        state_d  = SER_SHIFT;
                        shreg_d  = head_frame;
                        bitcnt_d = '0;
                    end
                end
                SER_SHIFT: begin
                    if (!last_bit) begin
                        shreg_d  = {1'b0, shreg_q[FRAME-1:1]};
                        bitcnt_d = bitcnt_q + CW'(1);
                    end else if (pop) begin
                        shreg_d  = head_frame;
                        bitcnt_d = '0;
                    end else begin
                        state_d  = SER_IDLE;
                        shreg_d  = '0;
                        bitcnt_d = '0;
                    end
                end
                default: state_d = SER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q  <= SER_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign in_if.in_ready = ~full & ~r;
    assign x_valid        = (state_q == SER_SHIFT);
    assign x              = x_valid ? shreg_q[0] : IDLE_X;
    assign busy           = x_valid | ~empty;

endmodule

// File: tb/tb_serial_stim_feeder.sv
// Self-checking bench for serial_stim_feeder (DATA_W=8, DEPTH=4) against a word-queue model.
module tb_serial_stim_feeder;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
`ifdef SER_PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif

    typedef logic [FRAME-1:0] frame_t;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       tick = 1'b0;
    logic       x, x_valid, busy;
    logic [2:0] level;

    int tests = 0;
    int fails = 0;

    // Model: queue of pending frames plus the frame on the wire and bits left in it.
    frame_t m_q[$];
    frame_t m_cur;
    int     m_rem = 0;

    serial_stim_feeder_if #(.DATA_W(DATA_W)) bus ();

    serial_stim_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .r       (r),
        .tick    (tick),
        .in_if   (bus),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .level   (level)
    );

    always #5 clk = ~clk;

    function automatic frame_t mk(input logic [7:0] w);
`ifdef SER_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    function automatic logic [6:0] exp_vec();
        logic ex;
        ex = (m_rem > 0) ? m_cur[FRAME - m_rem] : 1'b1;
        return {ex, (m_rem > 0), ((m_rem > 0) || (m_q.size() > 0)),
                ((m_q.size() < DEPTH) && !r), 3'(m_q.size())};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {x, x_valid, busy, bus.in_ready, level};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rem = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, land 1 time unit after it.
    task automatic cyc(input logic v, input logic [7:0] d, input logic t);
        logic acc;
        bus.in_valid = v;
        bus.in_data  = d;
        tick         = t;
        @(posedge clk);
        acc = v && (m_q.size() < DEPTH) && !r;
        if (t) begin
            if (m_rem <= 1) begin
                if (m_q.size() != 0) begin
                    m_cur = m_q.pop_front();
                    m_rem = FRAME;
                end else begin
                    m_rem = 0;
                end
            end else begin
                m_rem--;
            end
        end
        if (acc) m_q.push_back(mk(d));
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if (dut_vec() !== 7'b1_0_0_0_000) begin
            fails++;
            $display("FAIL reset_initial: got %b want %b", dut_vec(), 7'b1_0_0_0_000);
        end
        @(negedge clk);
        r = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
        cyc(1'b1, 8'h5A, 1'b1);
        cyc(1'b1, 8'hC3, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_traffic: got %b want %b", dut_vec(), exp_vec());
        end
        #3;
        r = 1'b1;
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== 7'b1_0_0_0_000) begin
            fails++;
            $display("FAIL reset_async: got %b want %b", dut_vec(), 7'b1_0_0_0_000);
        end
        @(posedge clk);
        #1;
        tests++;
        if (dut_vec() !== 7'b1_0_0_0_000) begin
            fails++;
            $display("FAIL reset_held: got %b want %b", dut_vec(), 7'b1_0_0_0_000);
        end
        @(negedge clk);
        r = 1'b0;
        #1;
    endtask

    task automatic test_single();
        logic [FRAME-1:0] got;
        logic [7:0]       want;
        want = 8'hA5;
        cyc(1'b1, want, 1'b1);
        tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL single_push: got %b want %b", dut_vec(), exp_vec());
        end
        for (int i = 0; i < FRAME; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            got[i] = x;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL single_bit%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (got[7:0] !== want) begin
            fails++;
            $display("FAIL single_word: got %h want %h", got[7:0], want);
        end
        cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if ({x, x_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL single_idle: got %b want 100", {x, x_valid, busy});
        end
    endtask

    task automatic test_fill();
        logic [7:0] w [4];
        logic       bits[$];
        logic [7:0] gw;
        bit         ended;
        ended = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            cyc(1'b1, w[i], 1'b0);
        end
        tests++;
        if ({level, bus.in_ready} !== 4'b100_0) begin
            fails++;
            $display("FAIL fill_full: got level=%0d ready=%b want level=4 ready=0", level, bus.in_ready);
        end
        cyc(1'b1, 8'h5A, 1'b0);
        tests++;
        if (level !== 3'd4) begin
            fails++;
            $display("FAIL fill_refused: got level=%0d want 4", level);
        end
        for (int c = 0; c < 4 * FRAME + 3; c++) begin
            cyc(1'b0, 8'h00, 1'b1);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL fill_cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
            if (x_valid) begin
                tests++;
                if (ended) begin
                    fails++;
                    $display("FAIL fill_gap: got x_valid=1 after drop at cycle %0d want contiguous", c);
                end
                bits.push_back(x);
            end else if (bits.size() > 0) begin
                ended = 1'b1;
            end
        end
        tests++;
        if (bits.size() != 4 * FRAME) begin
            fails++;
            $display("FAIL fill_count: got %0d want %0d", bits.size(), 4 * FRAME);
        end else begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 8; j++) gw[j] = bits[k * FRAME + j];
                tests++;
                if (gw !== w[k]) begin
                    fails++;
                    $display("FAIL fill_word%0d: got %h want %h", k, gw, w[k]);
                end
            end
        end
    endtask

    task automatic test_slow_tick();
        logic       bits[$];
        logic [7:0] want;
        logic [1:0] pair;
        want = 8'h3C;
        cyc(1'b1, want, 1'b0);
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            cyc(1'b0, 8'h00, (c % 2) == 0);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL slow_cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
            if (x_valid) bits.push_back(x);
        end
        tests++;
        if (bits.size() != 2 * FRAME) begin
            fails++;
            $display("FAIL slow_count: got %0d want %0d", bits.size(), 2 * FRAME);
        end else begin
            for (int j = 0; j < 8; j++) begin
                pair = {bits[2 * j], bits[2 * j + 1]};
                tests++;
                if (pair !== {2{want[j]}}) begin
                    fails++;
                    $display("FAIL slow_bit%0d: got %b want %b", j, pair, {2{want[j]}});
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [FRAME-1:0] got;
        logic [7:0]       want;
        cyc(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if ({x, x_valid} !== 2'b11) begin
            fails++;
            $display("FAIL mid_bit3: got %b want 11", {x, x_valid});
        end
        #2;
        r = 1'b1;
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== 7'b1_0_0_0_000) begin
            fails++;
            $display("FAIL mid_reset: got %b want %b", dut_vec(), 7'b1_0_0_0_000);
        end
        @(negedge clk);
        r = 1'b0;
        want = 8'h01;
        cyc(1'b1, want, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            got[i] = x;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL mid_bit%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (got[7:0] !== want) begin
            fails++;
            $display("FAIL mid_residue: got %h want %h", got[7:0], want);
        end
        cyc(1'b0, 8'h00, 1'b1);
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [8:0] got;
        logic [8:0] want [2];
        logic [7:0] word [2];
        word[0] = 8'h07; want[0] = 9'h107;
        word[1] = 8'h03; want[1] = 9'h003;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, word[k], 1'b1);
            for (int i = 0; i < 9; i++) begin
                cyc(1'b0, 8'h00, 1'b1);
                got[i] = x;
            end
            tests++;
            if (got !== want[k]) begin
                fails++;
                $display("FAIL parity_%h: got %b want %b", word[k], got, want[k]);
            end
            cyc(1'b0, 8'h00, 1'b1);
            tests++;
            if ({x, x_valid, busy} !== 3'b100) begin
                fails++;
                $display("FAIL parity_idle_%h: got %b want 100", word[k], {x, x_valid, busy});
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 3) != 0));
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rand_cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 6 * FRAME; c++) cyc(1'b0, 8'h00, 1'b1);
        tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL rand_drain: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        test_reset();
        test_single();
        test_fill();
        test_slow_tick();
        test_midframe_reset();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
